// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM: opcodes,
// ALUOp / PCSource / ALUSrcB codes, state encodings and the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// State-to-control-word decoder. Pure Moore except the FETCH IR/PC load,
// which waits for the instruction read to complete.
module ctrl_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALUOP_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // branch target precompute: PC + (imm << 2)
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: o_ctrl.reg_write = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state logic and reset gating of the decoded control word.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  logic   r_is_lw;
  logic   w_rdy;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  assign w_rdy = WAIT_MEM ? mem_ready : 1'b1;

  // Op is only valid in DECODE, so lw/sw is remembered for MEMADR.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_is_lw <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:  if (w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_lw <= (Op == OP_LW);
          case (Op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDIEX;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= r_is_lw ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (w_rdy) r_state <= S_MEMWB;
        S_MEMWR:   if (w_rdy) r_state <= S_FETCH;
        S_EXEC:    r_state <= S_RTYPEWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  ctrl_out_decode u_dec (
    .i_state     (r_state),
    .i_mem_ready (w_rdy),
    .o_ctrl      (w_ctrl)
  );

  assign w_out       = rst ? '0 : w_ctrl;
  assign PCWrite     = w_out.pc_write;
  assign PCWriteCond = w_out.pc_write_cond;
  assign IorD        = w_out.iord;
  assign MemRead     = w_out.mem_read;
  assign MemWrite    = w_out.mem_write;
  assign IRWrite     = w_out.ir_write;
  assign MemtoReg    = w_out.mem_to_reg;
  assign PCSource    = w_out.pc_source;
  assign ALUOp       = w_out.alu_op;
  assign ALUSrcA     = w_out.alu_src_a;
  assign ALUSrcB     = w_out.alu_src_b;
  assign RegWrite    = w_out.reg_write;
  assign RegDst      = w_out.reg_dst;
  assign illegal_op  = ~rst & (r_state == S_DECODE) & ~op_supported(Op);
  assign state       = r_state;

endmodule
